stream_demux: RTL and testbench

Registered, packet-aware 1-to-N stream demultiplexer: the routing counterpart of the `multiplexer` block. A single valid/ready input stream is steered, one whole packet at a time, to one of `NUM_OUTPUTS` valid/ready output channels, chosen by `sel` at the first beat of the packet. Each output channel has a one-entry output register. Packets addressed to a nonexistent channel are discarded and counted. It sits between a shared ingress stream and per-destination consumers.

---
 rtl/stream_demux_if.sv | 28 ++
 rtl/stream_demux.sv | 79 +++++++
 tb/tb_stream_demux.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/stream_demux_if.sv
// stream_demux_if: shared ingress stream plus per-channel egress streams and drop status.
interface stream_demux_if #(
   parameter int WIDTH       = 8,
   parameter int SEL_WIDTH   = 3,
   parameter int NUM_OUTPUTS = 8
);
   logic [SEL_WIDTH-1:0]         sel;
   logic [WIDTH-1:0]             in_data;
   logic                         in_valid;
   logic                         in_last;
   logic                         in_ready;
   logic [NUM_OUTPUTS*WIDTH-1:0] out_data;
   logic [NUM_OUTPUTS-1:0]       out_valid;
   logic [NUM_OUTPUTS-1:0]       out_last;
   logic [NUM_OUTPUTS-1:0]       out_ready;
   logic                         err;
   logic [7:0]                   drop_count;

   modport master (
      output sel, in_data, in_valid, in_last, out_ready,
      input  in_ready, out_data, out_valid, out_last, err, drop_count
   );

   modport slave (
      input  sel, in_data, in_valid, in_last, out_ready,
      output in_ready, out_data, out_valid, out_last, err, drop_count
   );
endinterface

// File: rtl/stream_demux.sv
// stream_demux: packet-aware 1-to-N valid/ready demultiplexer with one register per channel.
module stream_demux #(
   parameter int WIDTH       = 8,
   parameter int SEL_WIDTH   = 3,
   parameter int NUM_OUTPUTS = 8
) (
   input logic           clk,
   input logic           rst,
   stream_demux_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOCKED, DROP} state_e;

   state_e                       state_q, state_d;
   logic [SEL_WIDTH-1:0]         dest_q, dest_d;
   logic                         err_q, err_d;
   logic [7:0]                   cnt_q, cnt_d;
   logic [NUM_OUTPUTS*WIDTH-1:0] data_q;
   logic [NUM_OUTPUTS-1:0]       valid_q, last_q, load;
   logic [SEL_WIDTH-1:0]         tgt;
   logic                         sel_ok, route, in_ready, accept;

   // The first beat is routed by sel; later beats of the packet follow the latched dest.
   assign sel_ok   = {1'b0, bus.sel} < (SEL_WIDTH+1)'(NUM_OUTPUTS);
   assign tgt      = (state_q == LOCKED) ? dest_q : bus.sel;
   assign route    = (state_q == LOCKED) || (state_q == IDLE && sel_ok);
   assign in_ready = route ? (!valid_q[tgt] || bus.out_ready[tgt]) : 1'b1;
   assign accept   = bus.in_valid && in_ready;
   assign load     = (accept && route) ? (NUM_OUTPUTS'(1) << tgt) : '0;

   always_comb begin
      state_d = state_q;
      dest_d  = dest_q;
      err_d   = 1'b0;
      cnt_d   = cnt_q;
      if (accept) begin
         if (state_q == IDLE) begin
            dest_d  = sel_ok ? bus.sel : dest_q;
            err_d   = !sel_ok;
            cnt_d   = (!sel_ok && cnt_q != 8'hff) ? cnt_q + 8'd1 : cnt_q;
            state_d = bus.in_last ? IDLE : (sel_ok ? LOCKED : DROP);
         end else if (bus.in_last) begin
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         dest_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         data_q  <= '0;
         valid_q <= '0;
         last_q  <= '0;
      end else begin
         state_q <= state_d;
         dest_q  <= dest_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         for (int k = 0; k < NUM_OUTPUTS; k++) begin
            if (load[k]) begin
               data_q[k*WIDTH +: WIDTH] <= bus.in_data;
               last_q[k]                <= bus.in_last;
               valid_q[k]               <= 1'b1;
            end else if (bus.out_ready[k]) begin
               valid_q[k] <= 1'b0;
            end
         end
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.out_data   = data_q;
   assign bus.out_valid  = valid_q;
   assign bus.out_last   = last_q;
   assign bus.err        = err_q;
   assign bus.drop_count = cnt_q;
endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: scoreboard bench; unit 0 has 8 channels, unit 1 has 6 for invalid-destination cases.
module tb_stream_demux;
   typedef struct {
      logic [7:0] d;
      logic       l;
      int         c;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_wait = 0;
   exp_t q[2][8][$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   stream_demux_if ia ();
   stream_demux_if #(.NUM_OUTPUTS(6)) ib ();

   stream_demux u0 (.clk(clk), .rst(rst), .bus(ia.slave));
   stream_demux #(.NUM_OUTPUTS(6)) u1 (.clk(clk), .rst(rst), .bus(ib.slave));

   logic [7:0]  ovv[2], olv[2], rdv[2], dcv[2];
   logic [63:0] odv[2];
   logic        erv[2];
   assign ovv[0] = ia.out_valid;
   assign ovv[1] = {2'b00, ib.out_valid};
   assign olv[0] = ia.out_last;
   assign olv[1] = {2'b00, ib.out_last};
   assign rdv[0] = ia.out_ready;
   assign rdv[1] = {2'b11, ib.out_ready};
   assign odv[0] = ia.out_data;
   assign odv[1] = {16'h0, ib.out_data};
   assign erv[0] = ia.err;
   assign erv[1] = ib.err;
   assign dcv[0] = ia.drop_count;
   assign dcv[1] = ib.drop_count;

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", n, a, e);
      end
   endtask

   task automatic set_in(input int u, input logic v, input logic [2:0] s, input logic [7:0] d, input logic l);
      if (u == 0) begin
         ia.in_valid = v; ia.sel = s; ia.in_data = d; ia.in_last = l;
      end else begin
         ib.in_valid = v; ib.sel = s; ib.in_data = d; ib.in_last = l;
      end
   endtask

   function automatic logic rdy(input int u);
      return (u == 0) ? ia.in_ready : ib.in_ready;
   endfunction

   task automatic push(input int u, input int ch, input logic [7:0] d, input logic l);
      exp_t e;
      e.d = d; e.l = l; e.c = cyc;
      q[u][ch].push_back(e);
   endtask

   // One beat; expected output is queued at the acceptance point (ch < 0 means dropped).
   task automatic beat(input int u, input logic [2:0] s, input logic [7:0] d, input logic l, input int ch);
      int n = 0;
      set_in(u, 1'b1, s, d, l);
      @(negedge clk);
      while (!rdy(u) && n < 50) begin
         @(negedge clk);
         n++;
      end
      last_wait = n;
      if (n >= 50) begin
         checks++;
         errors++;
         $display("FAIL beat_timeout u%0d: got in_ready=0 for %0d cycles, required acceptance", u, n);
      end else if (ch >= 0) begin
         push(u, ch, d, l);
      end
      @(posedge clk); #1;
      set_in(u, 1'b0, 3'd0, 8'd0, 1'b0);
   endtask

   function automatic int pending();
      int p = 0;
      for (int u = 0; u < 2; u++)
         for (int k = 0; k < 8; k++) p += q[u][k].size();
      return p;
   endfunction

   task automatic drain();
      int n = 0;
      while (pending() != 0 && n < 30) begin
         @(posedge clk);
         n++;
      end
      @(posedge clk); #1;
      chk("drain_pending", 64'(pending()), 64'd0);
   endtask

   task automatic chk_reset();
      for (int u = 0; u < 2; u++) begin
         chk("rst_out_valid", 64'(ovv[u]), 64'd0);
         chk("rst_out_data", odv[u], 64'd0);
         chk("rst_out_last", 64'(olv[u]), 64'd0);
         chk("rst_err", 64'(erv[u]), 64'd0);
         chk("rst_drop_count", 64'(dcv[u]), 64'd0);
      end
   endtask

   // Monitor: every presented beat must match the queue head; a queued beat must show up one cycle after acceptance.
   always @(negedge clk) begin
      if (!rst) begin
         for (int u = 0; u < 2; u++) begin
            for (int k = 0; k < ((u == 0) ? 8 : 6); k++) begin
               if (ovv[u][k]) begin
                  checks++;
                  if (q[u][k].size() == 0) begin
                     errors++;
                     $display("FAIL unexpected_beat u%0d ch%0d: got valid data %0h, required idle", u, k, odv[u][k*8 +: 8]);
                  end else begin
                     if (odv[u][k*8 +: 8] !== q[u][k][0].d || olv[u][k] !== q[u][k][0].l) begin
                        errors++;
                        $display("FAIL beat u%0d ch%0d: got data %0h last %0b, required data %0h last %0b",
                                 u, k, odv[u][k*8 +: 8], olv[u][k], q[u][k][0].d, q[u][k][0].l);
                     end
                     if (rdv[u][k]) void'(q[u][k].pop_front());
                  end
               end else if (q[u][k].size() != 0) begin
                  checks++;
                  if (q[u][k][0].c < cyc) begin
                     errors++;
                     $display("FAIL latency u%0d ch%0d: got out_valid=0, required data %0h", u, k, q[u][k][0].d);
                  end
               end
            end
         end
      end
   end

   initial begin
      set_in(0, 1'b0, 3'd0, 8'd0, 1'b0);
      set_in(1, 1'b0, 3'd0, 8'd0, 1'b0);
      ia.out_ready = '1;
      ib.out_ready = '1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset();
      @(posedge clk); #1;
      rst = 1'b0;

      for (int s = 0; s < 8; s++) beat(0, 3'(s), 8'(s), 1'b1, s);
      drain();

      beat(0, 3'd2, 8'hA0, 1'b0, 2);
      beat(0, 3'd5, 8'hA1, 1'b0, 2);
      chk("lock_throughput", 64'(last_wait), 64'd0);
      beat(0, 3'd5, 8'hA2, 1'b0, 2);
      beat(0, 3'd5, 8'hA3, 1'b1, 2);
      chk("lock_throughput", 64'(last_wait), 64'd0);
      drain();

      ia.out_ready[3] = 1'b0;
      beat(0, 3'd3, 8'h30, 1'b1, 3);
      chk("bp_first_accept", 64'(last_wait), 64'd0);
      beat(0, 3'd1, 8'h10, 1'b1, 1);
      chk("bp_other_channel_accept", 64'(last_wait), 64'd0);
      set_in(0, 1'b1, 3'd3, 8'h31, 1'b1);
      repeat (2) begin
         @(negedge clk);
         chk("bp_stall_in_ready", 64'(ia.in_ready), 64'd0);
         chk("bp_held_valid", 64'(ia.out_valid[3]), 64'd1);
      end
      @(posedge clk); #1;
      ia.out_ready[3] = 1'b1;
      @(negedge clk);
      chk("bp_release_in_ready", 64'(ia.in_ready), 64'd1);
      push(0, 3, 8'h31, 1'b1);
      @(posedge clk); #1;
      set_in(0, 1'b0, 3'd0, 8'd0, 1'b0);
      drain();

      beat(1, 3'd7, 8'h70, 1'b0, -1);
      chk("drop_in_ready", 64'(last_wait), 64'd0);
      chk("drop_err_pulse", 64'(ib.err), 64'd1);
      chk("drop_count_1", 64'(ib.drop_count), 64'd1);
      beat(1, 3'd0, 8'h71, 1'b0, -1);
      chk("drop_in_ready", 64'(last_wait), 64'd0);
      chk("drop_err_once", 64'(ib.err), 64'd0);
      beat(1, 3'd7, 8'h72, 1'b1, -1);
      chk("drop_in_ready", 64'(last_wait), 64'd0);
      chk("drop_err_once", 64'(ib.err), 64'd0);
      chk("drop_count_held", 64'(ib.drop_count), 64'd1);
      beat(1, 3'd0, 8'h55, 1'b1, 0);
      chk("route_after_drop_err", 64'(ib.err), 64'd0);
      drain();

      for (int i = 0; i < 300; i++) begin
         beat(1, 3'd6, 8'(i), 1'b1, -1);
         chk("sat_err_pulse", 64'(ib.err), 64'd1);
         if (i == 253) chk("sat_reach_255", 64'(ib.drop_count), 64'd255);
      end
      chk("sat_hold_255", 64'(ib.drop_count), 64'd255);
      @(posedge clk); #1;
      chk("sat_err_clear", 64'(ib.err), 64'd0);

      beat(0, 3'd4, 8'h40, 1'b0, 4);
      beat(0, 3'd4, 8'h41, 1'b0, 4);
      rst = 1'b1;
      for (int u = 0; u < 2; u++)
         for (int k = 0; k < 8; k++) q[u][k].delete();
      @(posedge clk);
      @(negedge clk);
      chk_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      beat(0, 3'd6, 8'h42, 1'b0, 6);
      beat(0, 3'd6, 8'h43, 1'b1, 6);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
